tt_ternary_weight_loader: RTL

Byte-serial loader that fills the ternary weight matrix consumed by the ternary matrix-vector multiplier. It accepts a stream of 8-bit bytes, each packing four 2-bit ternary weights, and stages them in a shadow buffer. When the full InLen×OutLen matrix has arrived, it commits the buffer atomically to the parallel weight bus. The multiplier therefore never sees a partially written matrix, and the previous weights stay in use throughout a reload.

---
 rtl/tt_ternary_weight_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/tt_ternary_weight_loader.sv
// Byte-serial ternary weight loader: stages packed 2-bit weights in a shadow
// buffer and commits the whole matrix to W_out in one edge once complete.
module tt_ternary_weight_loader #(
    parameter int InLen  = 16,
    parameter int OutLen = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [7:0]                   data_in,
    input  logic                         data_valid,
    output logic                         ready,
    output logic [2*InLen*OutLen-1:0]    W_out,
    output logic                         weights_valid,
    output logic                         load_done,
    output logic                         code_err
);

    localparam int NW = InLen * OutLen;
    localparam int NB = NW / 4;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [2*NW-1:0]  shadow_reg;
    logic [2*NW-1:0]  merged;
    logic [7:0]       byte_dec;
    logic [3:0]       bad;
    logic             accept;
    logic             last;

    // Invalid code 2'b10 is stored as zero weight and flagged.
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
        assign bad[gi]              = (data_in[2*gi+1 -: 2] == 2'b10);
        assign byte_dec[2*gi +: 2]  = bad[gi] ? 2'b00 : data_in[2*gi +: 2];
    end

    assign accept = (state_reg == LOAD) && data_valid && !load_start;
    assign last   = (cnt_reg == CW'(NB - 1));

    // Shadow has no reset: its contents are fully rewritten before any commit.
    for (genvar gi = 0; gi < NB; gi++) begin : g_shadow
        always_ff @(posedge clk) begin
            if (accept && cnt_reg == CW'(gi)) begin
                shadow_reg[8*gi +: 8] <= byte_dec;
            end
        end
        assign merged[8*gi +: 8] = (cnt_reg == CW'(gi)) ? byte_dec : shadow_reg[8*gi +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            W_out         <= '0;
            weights_valid <= 1'b0;
            load_done     <= 1'b0;
            code_err      <= 1'b0;
            ready         <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        state_reg <= LOAD;
                        ready     <= 1'b1;
                        cnt_reg   <= '0;
                        code_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    // A restart discards the byte presented in the same cycle.
                    if (load_start) begin
                        cnt_reg  <= '0;
                        code_err <= 1'b0;
                    end else if (data_valid) begin
                        if (|bad) begin
                            code_err <= 1'b1;
                        end
                        if (last) begin
                            W_out         <= merged;
                            weights_valid <= 1'b1;
                            load_done     <= 1'b1;
                            state_reg     <= IDLE;
                            ready         <= 1'b0;
                            cnt_reg       <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
